// File: rtl/stall_ctrl.sv
// -----------------------------------------------------------------------------
// stall_ctrl -- pipeline stall / flush controller for a 5-stage in-order core.
//
// Sequences the pipeline through IDLE -> RUN, stalls the whole pipe while a
// multi-cycle data access is outstanding (MEM_WAIT), and parks in HALT with a
// sticky error if memory fails to acknowledge within MEM_TIMEOUT cycles.
// In RUN the priority is mem_req_i > hazard_i > flush_i.
//
// Optional feature: define STALL_CTRL_STALL_CNT_EN to add the saturating
// stall-cycle counter and its stall_cnt_o port.
//
// Parameters
//   MEM_TIMEOUT  max cycles spent in MEM_WAIT before HALT (1..1023)
//   CNT_W        stall-cycle counter width
//
// Ports
//   clk_i          clock, rising edge
//   rst_i          asynchronous active-low reset
//   start_i        leave IDLE and start executing
//   hazard_i       load-use hazard: hold PC and IF/ID, bubble ID/EX
//   flush_i        taken branch/jump: clear IF/ID
//   mem_req_i      MEM stage needs a multi-cycle access
//   mem_ack_i      memory has completed the outstanding access
//   pc_write_o     PC advance enable
//   ifid_write_o   IF/ID write enable
//   ifid_flush_o   clear IF/ID to NOP
//   idex_bubble_o  load NOP control into ID/EX
//   exmem_write_o  EX/MEM write enable
//   memwb_write_o  MEM/WB write enable
//   error_o        sticky memory-timeout flag
//   stall_cnt_o    stall-cycle count (STALL_CTRL_STALL_CNT_EN only)
// -----------------------------------------------------------------------------
module stall_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             hazard_i,
    input  logic             flush_i,
    input  logic             mem_req_i,
    input  logic             mem_ack_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             exmem_write_o,
    output logic             memwb_write_o,
    output logic             error_o
`ifdef STALL_CTRL_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt_o
`endif
);

    typedef enum logic [1:0] {StIdle, StRun, StMemWait, StHalt} state_e;

    // Wait counter holds the number of completed MEM_WAIT cycles; 10 bits
    // covers the full MEM_TIMEOUT range.
    localparam logic [9:0] WaitLast = 10'(MEM_TIMEOUT - 1);

    state_e     state_q, state_d;
    logic [9:0] wait_cnt_q, wait_cnt_d;
    logic       error_q, error_d;
    logic       timeout;

    // Last permitted MEM_WAIT cycle passes without an ack.
    assign timeout = (state_q == StMemWait) && !mem_ack_i && (wait_cnt_q == WaitLast);

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) state_d = StRun;
            end
            StRun: begin
                // A same-cycle ack makes the access single-cycle.
                if (mem_req_i && !mem_ack_i) state_d = StMemWait;
            end
            StMemWait: begin
                if (mem_ack_i) begin
                    state_d = StRun;
                end else if (timeout) begin
                    state_d = StHalt;
                end
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: state_d = StIdle;
        endcase
    end

    // Output logic.
    always_comb begin
        pc_write_o    = 1'b0;
        ifid_write_o  = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
        exmem_write_o = 1'b0;
        memwb_write_o = 1'b0;
        unique case (state_q)
            StRun: begin
                if (mem_req_i && !mem_ack_i) begin
                    // Whole pipe frozen while the access starts.
                    pc_write_o    = 1'b0;
                end else if (mem_req_i) begin
                    pc_write_o    = 1'b1;
                    ifid_write_o  = 1'b1;
                    exmem_write_o = 1'b1;
                    memwb_write_o = 1'b1;
                end else if (hazard_i) begin
                    // Hold PC and IF/ID so the consumer re-decodes; one bubble.
                    idex_bubble_o = 1'b1;
                    exmem_write_o = 1'b1;
                    memwb_write_o = 1'b1;
                end else begin
                    pc_write_o    = 1'b1;
                    ifid_write_o  = 1'b1;
                    ifid_flush_o  = flush_i;
                    exmem_write_o = 1'b1;
                    memwb_write_o = 1'b1;
                end
            end
            StIdle, StMemWait, StHalt: begin
                pc_write_o = 1'b0;
            end
            default: pc_write_o = 1'b0;
        endcase
    end

    // Wait counter and sticky error.
    always_comb begin
        wait_cnt_d = (state_q == StMemWait) ? wait_cnt_q + 10'd1 : 10'd0;
        error_d    = error_q | timeout;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wait_cnt_q <= 10'd0;
            error_q    <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            error_q    <= error_d;
        end
    end

    assign error_o = error_q;

`ifdef STALL_CTRL_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic             stall_cycle;

    assign stall_cycle = ((state_q == StRun) || (state_q == StMemWait)) && !pc_write_o;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_q <= '0;
        end else if (stall_cycle && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    // Counter absent; CNT_W is kept only so both builds share one interface.
    logic [CNT_W-1:0] unused_stall_cnt;
    assign unused_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_stall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stall_ctrl -- directed bench for stall_ctrl.
// Two instances share one stimulus stream: dut_a with the default timeout and
// dut_b with MEM_TIMEOUT=4. A behavioural model per instance predicts every
// output each cycle; literal checks pin key scenarios independently.
// -----------------------------------------------------------------------------
module tb_stall_ctrl;

    localparam int unsigned CntW = 16;

    logic clk = 1'b0;
    logic rst, start, hazard, flush, mem_req, mem_ack;

    logic pc_a, ifid_a, fl_a, bub_a, ex_a, wb_a, err_a;
    logic pc_b, ifid_b, fl_b, bub_b, ex_b, wb_b, err_b;
`ifdef STALL_CTRL_STALL_CNT_EN
    logic [CntW-1:0] scnt [2];
`endif

    always #5 clk = ~clk;

    stall_ctrl #(.MEM_TIMEOUT(255), .CNT_W(CntW)) dut_a (
        .clk_i(clk), .rst_i(rst), .start_i(start), .hazard_i(hazard), .flush_i(flush),
        .mem_req_i(mem_req), .mem_ack_i(mem_ack),
        .pc_write_o(pc_a), .ifid_write_o(ifid_a), .ifid_flush_o(fl_a),
        .idex_bubble_o(bub_a), .exmem_write_o(ex_a), .memwb_write_o(wb_a),
        .error_o(err_a)
`ifdef STALL_CTRL_STALL_CNT_EN
        , .stall_cnt_o(scnt[0])
`endif
    );

    stall_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CntW)) dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(start), .hazard_i(hazard), .flush_i(flush),
        .mem_req_i(mem_req), .mem_ack_i(mem_ack),
        .pc_write_o(pc_b), .ifid_write_o(ifid_b), .ifid_flush_o(fl_b),
        .idex_bubble_o(bub_b), .exmem_write_o(ex_b), .memwb_write_o(wb_b),
        .error_o(err_b)
`ifdef STALL_CTRL_STALL_CNT_EN
        , .stall_cnt_o(scnt[1])
`endif
    );

    // {pc, ifid, flush, bubble, exmem, memwb, error}
    logic [6:0] act [2];
    assign act[0] = {pc_a, ifid_a, fl_a, bub_a, ex_a, wb_a, err_a};
    assign act[1] = {pc_b, ifid_b, fl_b, bub_b, ex_b, wb_b, err_b};

    localparam logic [6:0] ORun    = 7'b1100110;
    localparam logic [6:0] OHazard = 7'b0001110;
    localparam logic [6:0] OFlush  = 7'b1110110;
    localparam logic [6:0] OZero   = 7'b0000000;
    localparam logic [6:0] OHalt   = 7'b0000001;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input int idx, input logic [31:0] got,
                         input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s[%0d] at %0t: got %0h want %0h", name, idx, $time, got, want);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int MIdle = 0, MRun = 1, MWait = 2, MHalt = 3;
    int      mode    [2] = '{MIdle, MIdle};
    int      waited  [2] = '{0, 0};
    bit      merr    [2] = '{1'b0, 1'b0};
    longint  mstall  [2] = '{0, 0};
    int      tmo     [2] = '{255, 4};
    longint  stall_max = (longint'(1) << CntW) - 1;

    function automatic logic [6:0] expect_for(input int k);
        logic [6:0] o;
        if (!rst) return OZero;
        o = OZero;
        if (mode[k] == MRun) begin
            if (mem_req && !mem_ack)  o = OZero;
            else if (mem_req)         o = ORun;
            else if (hazard)          o = OHazard;
            else if (flush)           o = OFlush;
            else                      o = ORun;
        end
        o[0] = merr[k];
        return o;
    endfunction

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic [6:0] e;
            e = expect_for(k);
            check("outputs", k, 32'(act[k]), 32'(e));
`ifdef STALL_CTRL_STALL_CNT_EN
            check("stall_cnt", k, 32'(scnt[k]), 32'(mstall[k]));
`endif
            if (!rst) begin
                mode[k] = MIdle; waited[k] = 0; merr[k] = 1'b0; mstall[k] = 0;
            end else begin
                if ((mode[k] == MRun || mode[k] == MWait) && !e[6] && mstall[k] < stall_max)
                    mstall[k]++;
                case (mode[k])
                    MIdle: if (start) mode[k] = MRun;
                    MRun:  if (mem_req && !mem_ack) begin mode[k] = MWait; waited[k] = 0; end
                    MWait: begin
                        if (mem_ack) mode[k] = MRun;
                        else begin
                            waited[k]++;
                            if (waited[k] >= tmo[k]) begin mode[k] = MHalt; merr[k] = 1'b1; end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int nstall;
    int base_cnt;

    initial begin
        rst = 1'b0; start = 1'b0; hazard = 1'b0; flush = 1'b0;
        mem_req = 1'b0; mem_ack = 1'b0;
        nstall = 0; base_cnt = 0;
        tick(); tick();
        #2;
        check("reset_a", 0, 32'(act[0]), 32'(OZero));
        check("reset_b", 1, 32'(act[1]), 32'(OZero));
        rst = 1'b1; tick();
        check("idle_a", 0, 32'(act[0]), 32'(OZero));
        start = 1'b1; tick();
        start = 1'b0; #2;
        check("run_after_start", 0, 32'(act[0]), 32'(ORun));
        start = 1'b1; tick();                       // ignored in RUN
        start = 1'b0; flush = 1'b1; #2;
        check("flush_only", 0, 32'(act[0]), 32'(OFlush));
        tick();
        flush = 1'b0; hazard = 1'b1; #2;
        check("hazard", 0, 32'(act[0]), 32'(OHazard));
        tick();
        hazard = 1'b0; #2;
        check("after_hazard", 0, 32'(act[0]), 32'(ORun));
        tick();
        hazard = 1'b1; flush = 1'b1; #2;
        check("hazard_and_flush", 0, 32'(act[0]), 32'(OHazard));
        tick();
        hazard = 1'b0; #2;
        check("flush_represented", 0, 32'(act[0]), 32'(OFlush));
        tick();
        flush = 1'b0; mem_req = 1'b1; mem_ack = 1'b1; #2;
        check("single_cycle_mem", 0, 32'(act[0]), 32'(ORun));
        tick();

        // Multi-cycle access: request cycle + 5 waits, ack in the last wait.
        mem_ack = 1'b0;
        for (int i = 0; i <= 6; i++) begin
            mem_ack = (i == 5);
            hazard  = (i == 2);
            flush   = (i == 2);
            if (i == 6) mem_req = 1'b0;
            #2;
`ifdef STALL_CTRL_STALL_CNT_EN
            if (i == 0) base_cnt = int'(scnt[0]);
            if (i == 6) check("stall_cnt_delta", 0, 32'(int'(scnt[0]) - base_cnt), 32'd6);
`endif
            if (!pc_a) nstall++;
            if (i == 4) check("b_before_timeout", 1, 32'(act[1]), 32'(OZero));
            if (i == 5) check("b_halted", 1, 32'(act[1]), 32'(OHalt));
            if (i == 6) check("a_back_to_run", 0, 32'(act[0]), 32'(ORun));
            tick();
        end
        hazard = 1'b0; flush = 1'b0;
        check("stall_cycles", 0, 32'(nstall), 32'd6);

        // HALT ignores start/ack.
        start = 1'b1; mem_ack = 1'b1;
        tick(); tick();
        start = 1'b0; mem_ack = 1'b0; #2;
        check("halt_sticky", 1, 32'(act[1]), 32'(OHalt));

        // Async reset in the middle of a MEM_WAIT.
        mem_req = 1'b1; tick();
        mem_req = 1'b0; tick(); tick();
        #2 rst = 1'b0;
        #1;
        check("async_reset_a", 0, 32'(act[0]), 32'(OZero));
        check("async_reset_b", 1, 32'(act[1]), 32'(OZero));
        tick();
        rst = 1'b1; tick();
        start = 1'b1; tick();
        start = 1'b0;

        // Timeout with the request held and no ack.
        mem_req = 1'b1;
        for (int i = 0; i <= 5; i++) begin
            #2;
            if (i == 4) check("timeout_not_yet", 1, 32'(act[1]), 32'(OZero));
            if (i == 5) check("timeout_halt", 1, 32'(act[1]), 32'(OHalt));
            tick();
        end
        mem_ack = 1'b1; tick();
        mem_req = 1'b0; mem_ack = 1'b0; #2;
        check("a_release", 0, 32'(act[0]), 32'(ORun));
        tick(); tick();
        rst = 1'b0; tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/stall_ctrl.md
STALL_CTRL -- requirements
Module: stall_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 255: maximum cycles in MEM_WAIT before error; range 1..1023.
REQ-002 Parameter CNT_W, default 16: width of the stall-cycle counter.
REQ-003 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_i  input  1  asynchronous, active-low reset.
REQ-005 start_i  input  1  leave IDLE and begin pipeline execution.
REQ-006 hazard_i  input  1  load-use hazard detected between ID/EX load and IF/ID consumer.
REQ-007 flush_i  input  1  taken branch/jump resolved in ID; discard the IF/ID instruction.
REQ-008 mem_req_i  input  1  MEM stage holds a data access needing multi-cycle memory.
REQ-009 mem_ack_i  input  1  memory completes the outstanding access.
REQ-010 pc_write_o  output  1  PC update enable (1 = advance).
REQ-011 ifid_write_o  output  1  IF/ID register write enable.
REQ-012 ifid_flush_o  output  1  clear IF/ID to NOP.
REQ-013 idex_bubble_o  output  1  load NOP control bits into ID/EX.
REQ-014 exmem_write_o, memwb_write_o  output  1 each  EX/MEM and MEM/WB write enables.
REQ-015 error_o  output  1  sticky memory-timeout flag.
REQ-016 stall_cnt_o  output  CNT_W  stall-cycle count (present only with STALL_CNT_EN).

Function
REQ-017 States SHALL be IDLE, RUN, MEM_WAIT, HALT, held in a registered state variable.
REQ-018 IDLE: all write enables 0, ifid_flush_o 0, idex_bubble_o 0; next RUN when start_i=1.
REQ-019 RUN, priority mem_req_i > hazard_i > flush_i, outputs combinational from state and inputs.
REQ-020 RUN with no request: pc_write_o, ifid_write_o, exmem_write_o, memwb_write_o all 1; flush/bubble 0.
REQ-021 RUN with mem_req_i=1 (mem_ack_i=0): all four write enables 0 same cycle, idex_bubble_o 0, ifid_flush_o 0; next MEM_WAIT.
REQ-022 RUN with mem_req_i=1 and mem_ack_i=1 same cycle: treated as single-cycle access; normal RUN outputs, stay RUN.
REQ-023 RUN with hazard_i=1 (no mem_req_i): pc_write_o=0, ifid_write_o=0, idex_bubble_o=1, exmem/memwb writes 1; exactly one bubble per asserted cycle.
REQ-024 RUN with flush_i=1 (no mem_req_i, no hazard_i): ifid_flush_o=1, all writes 1; simultaneous hazard_i suppresses flush that cycle (flush_i re-presents next cycle).
REQ-025 MEM_WAIT: all write enables 0, flush/bubble 0, regardless of hazard_i/flush_i; next RUN on mem_ack_i=1 (outputs stay stalled during the ack cycle).
REQ-026 Wait counter SHALL clear on MEM_WAIT entry, increment each MEM_WAIT cycle; reaching MEM_TIMEOUT without ack: next HALT, error_o set.
REQ-027 HALT: all enables 0, flush/bubble 0; exited only by reset; error_o held 1.
REQ-028 start_i ignored outside IDLE; mem_ack_i ignored outside RUN/MEM_WAIT.

Reset
REQ-029 rst_i=0 SHALL immediately force state IDLE, wait counter 0, error_o 0, stall_cnt_o 0, all enables/flush/bubble 0, including mid-MEM_WAIT.
REQ-030 First state change after rst_i deasserts occurs on the following rising clock edge.

Configuration
REQ-031 Macro STALL_CTRL_STALL_CNT_EN defined: stall_cnt_o present; increments by 1 each cycle pc_write_o=0 in RUN or MEM_WAIT; saturates at all-ones.
REQ-032 Macro undefined: port stall_cnt_o and counter logic absent; all other behaviour identical.

Verification
REQ-033 Reset low, start_i=1 one cycle, idle -> RUN next cycle, all four write enables 1, error_o 0.
REQ-034 RUN, hazard_i=1 one cycle -> that cycle pc_write_o=0, ifid_write_o=0, idex_bubble_o=1; next cycle all enables 1.
REQ-035 RUN, mem_req_i=1, mem_ack_i after 5 cycles -> enables 0 for 6 cycles total, RUN afterwards; stall_cnt_o=6 with macro.
REQ-036 MEM_TIMEOUT=4, mem_req_i=1, no ack -> HALT after 4 MEM_WAIT cycles, error_o=1 until rst_i=0.
REQ-037 RUN, hazard_i=1 and flush_i=1 together -> idex_bubble_o=1, ifid_flush_o=0; next cycle flush_i alone -> ifid_flush_o=1.
REQ-038 rst_i pulsed low mid-MEM_WAIT -> outputs zero asynchronously, IDLE, counters 0.
